// File: rtl/snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : snn_timestep_scheduler
// Brief    : Sequences one SNN inference over a row of integrate-and-fire PEs,
//            one input row per cycle, with per-PE saturating spike counters.
// Revision : 1.0 - initial release
// ============================================================================
module snn_timestep_scheduler #(
    parameter int N_IN    = 16,
    parameter int N_OUT   = 8,
    parameter int T_STEPS = 8,
    parameter int LAT     = 2,
    parameter int CW      = 8,
    localparam int AW     = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int TW     = (T_STEPS > 1) ? $clog2(T_STEPS) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  spk_valid,
    output logic                  spk_ready,
    input  logic [2*N_IN-1:0]     spk_data,
    output logic [AW-1:0]         w_rd_addr,
    output logic                  pe_rstn,
    output logic                  pe_in_spike,
    output logic                  pe_in_polarity,
    input  logic [N_OUT-1:0]      pe_out_spike,
    output logic                  out_valid,
    output logic [N_OUT-1:0]      out_spikes,
    output logic [N_OUT*CW-1:0]   spike_counts,
    output logic [TW-1:0]         timestep
);

    localparam int LCW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_SAMPLE = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    logic [2:0]       r_state;
    logic [AW-1:0]    r_row;
    logic [LCW-1:0]   r_lat;
    logic [N_IN-1:0]  r_spk;
    logic [N_IN-1:0]  r_pol;
    logic             r_pe_in_spike;
    logic             r_pe_in_pol;
    logic             r_out_valid;
    logic [N_OUT-1:0] r_out_spikes;
    logic [TW-1:0]    r_timestep;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_lat         <= '0;
            r_spk         <= '0;
            r_pol         <= '0;
            r_pe_in_spike <= 1'b0;
            r_pe_in_pol   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_spikes  <= '0;
            r_timestep    <= '0;
        end else begin
            r_pe_in_spike <= 1'b0;
            r_pe_in_pol   <= 1'b0;
            r_out_valid   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_timestep   <= '0;
                    r_out_spikes <= '0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (spk_valid) begin
                        r_spk   <= spk_data[N_IN-1:0];
                        r_pol   <= spk_data[2*N_IN-1:N_IN];
                        r_row   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Registered one cycle so the PE sees the spike alongside SRAM data
                    r_pe_in_spike <= r_spk[r_row];
                    r_pe_in_pol   <= r_pol[r_row];
                    if (r_row == AW'(N_IN - 1)) begin
                        r_lat   <= '0;
                        r_state <= (LAT == 0) ? S_SAMPLE : S_DRAIN;
                    end else begin
                        r_row <= r_row + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_lat == LCW'(LAT - 1)) r_state <= S_SAMPLE;
                    else                        r_lat   <= r_lat + LCW'(1);
                end
                S_SAMPLE: begin
                    r_out_spikes <= pe_out_spike;
                    r_out_valid  <= 1'b1;
                    if (r_timestep == TW'(T_STEPS - 1)) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_timestep <= r_timestep + TW'(1);
                        r_state    <= S_WAIT;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
            logic [CW-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (!rstn || r_state == S_CLEAR) begin
                    r_cnt <= '0;
                end else if (r_state == S_SAMPLE && pe_out_spike[k] && !(&r_cnt)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            assign spike_counts[k*CW +: CW] = r_cnt;
        end
    endgenerate

    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_FINISH);
    assign spk_ready      = (r_state == S_WAIT);
    assign w_rd_addr      = (r_state == S_ISSUE) ? r_row : '0;
    assign pe_rstn        = rstn & (r_state != S_CLEAR);
    assign pe_in_spike    = r_pe_in_spike;
    assign pe_in_polarity = r_pe_in_pol;
    assign out_valid      = r_out_valid;
    assign out_spikes     = r_out_spikes;
    assign timestep       = r_timestep;

endmodule
`default_nettype wire

// File: tb/tb_snn_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_timestep_scheduler
// Brief    : Self-checking bench with a weight SRAM / IF-PE row environment and
//            a timestep-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snn_timestep_scheduler;

    localparam int N_IN    = 16;
    localparam int N_OUT   = 8;
    localparam int T_STEPS = 8;
    localparam int LAT     = 2;
    localparam int CW      = 3;
    localparam int AW      = 4;
    localparam int TW      = 3;
    localparam int PERIOD  = N_IN + LAT + 2;
    localparam int SAT     = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                rstn, start, spk_valid;
    logic [2*N_IN-1:0]   spk_data;
    logic                busy, done, spk_ready, pe_rstn, pe_in_spike, pe_in_polarity, out_valid;
    logic [AW-1:0]       w_rd_addr;
    logic [N_OUT-1:0]    pe_out;
    logic [N_OUT-1:0]    out_spikes;
    logic [N_OUT*CW-1:0] spike_counts;
    logic [TW-1:0]       timestep;

    snn_timestep_scheduler #(
        .N_IN(N_IN), .N_OUT(N_OUT), .T_STEPS(T_STEPS), .LAT(LAT), .CW(CW)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_data(spk_data),
        .w_rd_addr(w_rd_addr), .pe_rstn(pe_rstn), .pe_in_spike(pe_in_spike),
        .pe_in_polarity(pe_in_polarity), .pe_out_spike(pe_out),
        .out_valid(out_valid), .out_spikes(out_spikes),
        .spike_counts(spike_counts), .timestep(timestep)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: 1-cycle-latency weight SRAM feeding a row of IF neurons
    logic signed [15:0] wmem [N_IN][N_OUT];
    logic signed [15:0] w_q  [N_OUT];
    int                 mem_v [N_OUT];
    int                 th;

    always @(posedge clk) begin
        for (int k = 0; k < N_OUT; k++) begin
            w_q[k] <= wmem[w_rd_addr][k];
            if (pe_in_spike)
                mem_v[k] <= mem_v[k] + (pe_in_polarity ? int'(w_q[k]) : -int'(w_q[k]));
            else if (!pe_rstn)
                mem_v[k] <= 0;
            pe_out[k] <= (!pe_rstn && !pe_in_spike) ? 1'b0 : (mem_v[k] >= th);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [N_IN-1:0]     vs_spk [T_STEPS];
    logic [N_IN-1:0]     vs_pol [T_STEPS];
    logic [N_OUT-1:0]    exp_spk [T_STEPS];
    logic [N_OUT*CW-1:0] exp_counts;
    logic [N_IN*AW-1:0]  exp_addr;

    logic [N_OUT-1:0]    obs_spk  [T_STEPS];
    logic [N_IN+1:0]     obs_pin  [T_STEPS];
    logic [N_IN*AW-1:0]  obs_addr [T_STEPS];
    logic [TW-1:0]       obs_ts   [T_STEPS];
    int                  obs_hs   [T_STEPS];
    int                  obs_lat  [T_STEPS];
    int                  c0, done_lat;
    logic [N_OUT*CW-1:0] obs_counts, counts_after;
    bit                  busy_ok, stall_ok, busy_after;

    task automatic randomize_stim(input int wmax);
        for (int r = 0; r < N_IN; r++)
            for (int k = 0; k < N_OUT; k++)
                wmem[r][k] = 16'(int'($urandom_range(2 * wmax)) - wmax);
        for (int s = 0; s < T_STEPS; s++) begin
            vs_spk[s] = N_IN'($urandom);
            vs_pol[s] = N_IN'($urandom);
        end
        th = int'($urandom_range(40)) - 20;
    endtask

    // Timestep-level model: membranes accumulate signed weighted spikes
    task automatic compute_model;
        int m [N_OUT];
        int c [N_OUT];
        for (int k = 0; k < N_OUT; k++) begin
            m[k] = 0;
            c[k] = 0;
        end
        for (int s = 0; s < T_STEPS; s++) begin
            for (int k = 0; k < N_OUT; k++) begin
                for (int r = 0; r < N_IN; r++)
                    if (vs_spk[s][r])
                        m[k] += vs_pol[s][r] ? int'(wmem[r][k]) : -int'(wmem[r][k]);
                exp_spk[s][k] = (m[k] >= th);
                if (m[k] >= th && c[k] < SAT) c[k]++;
            end
        end
        for (int k = 0; k < N_OUT; k++) exp_counts[k*CW +: CW] = CW'(c[k]);
    endtask

    task automatic wait_ready(output bit ok);
        int k = 0;
        while (!spk_ready && k < 64) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        ok = spk_ready;
    endtask

    task automatic run_inference(input int stall_step, input int stall_len, input int extra_start_step);
        int k;
        bit ok;
        @(negedge clk);
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start    = 1'b0;
        busy_ok  = 1'b1;
        stall_ok = 1'b1;
        for (int s = 0; s < T_STEPS; s++) begin
            wait_ready(ok);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL ready_timeout step %0d: spk_ready=%b required 1", s, spk_ready);
                return;
            end
            obs_ts[s] = timestep;
            if (s == stall_step)
                for (int i = 0; i < stall_len; i++) begin
                    if (!spk_ready || pe_in_spike) stall_ok = 1'b0;
                    @(negedge clk);
                end
            if (s == extra_start_step) start = 1'b1;
            spk_valid = 1'b1;
            spk_data  = {vs_pol[s], vs_spk[s]};
            obs_hs[s] = cyc;
            @(negedge clk);
            spk_valid   = 1'b0;
            start       = 1'b0;
            spk_data    = $urandom;
            obs_pin[s]  = '0;
            obs_addr[s] = '0;
            obs_lat[s]  = -1;
            for (k = 1; k < N_IN + LAT + 12; k++) begin
                if (k <= N_IN + 2) obs_pin[s][k-1] = pe_in_spike;
                if (k <= N_IN)     obs_addr[s][(k-1)*AW +: AW] = w_rd_addr;
                if (out_valid) begin
                    obs_lat[s] = k;
                    obs_spk[s] = out_spikes;
                    break;
                end
                if (!busy) busy_ok = 1'b0;
                @(negedge clk);
            end
            if (obs_lat[s] < 0) begin
                n_checks++; n_fail++;
                $display("FAIL out_valid_timeout step %0d: out_valid=%b required 1", s, out_valid);
                return;
            end
        end
        k = 0;
        while (!done && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: done=%b required 1", done);
            return;
        end
        done_lat   = cyc - c0;
        obs_counts = spike_counts;
        @(negedge clk);
        busy_after   = busy;
        counts_after = spike_counts;
    endtask

    task automatic test_reset;
        int  k;
        bit  ok, seen;
        rstn = 1'b0; start = 1'b0; spk_valid = 1'b0; spk_data = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, spk_ready, pe_rstn, pe_in_spike, pe_in_polarity, out_valid} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {busy, done, spk_ready, pe_rstn, pe_in_spike, pe_in_polarity, out_valid});
        end
        n_checks++;
        if ({spike_counts, out_spikes, timestep, w_rd_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: counts=%h spikes=%h ts=%0d addr=%0d required all 0",
                     spike_counts, out_spikes, timestep, w_rd_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pe_rstn !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: pe_rstn=%b busy=%b required 1 0", pe_rstn, busy);
        end
        // Fire every step, then abort partway through the second timestep
        for (int r = 0; r < N_IN; r++)
            for (int p = 0; p < N_OUT; p++) wmem[r][p] = 16'sd1;
        th = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready(ok);
        spk_valid = 1'b1;
        spk_data  = '1;
        @(negedge clk);
        spk_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (spike_counts !== {N_OUT{CW'(1)}}) begin
            n_fail++;
            $display("FAIL counts_before_abort: got %h required %h", spike_counts, {N_OUT{CW'(1)}});
        end
        wait_ready(ok);
        spk_valid = 1'b1;
        @(negedge clk);
        spk_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || pe_in_spike !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_issue: busy=%b pe_in_spike=%b required 1 1", busy, pe_in_spike);
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, pe_rstn, pe_in_spike} !== 3'b000 || spike_counts !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: busy=%b pe_rstn=%b pe_in=%b counts=%h required 0 0 0 0",
                     busy, pe_rstn, pe_in_spike, spike_counts);
        end
        rstn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL no_done_after_abort: activity=%b required 0", seen);
        end
    endtask

    task automatic test_saturation;
        for (int r = 0; r < N_IN; r++)
            for (int k = 0; k < N_OUT; k++) wmem[r][k] = 16'sd1;
        for (int s = 0; s < T_STEPS; s++) begin
            vs_spk[s] = '1;
            vs_pol[s] = '1;
        end
        th = 16;
        compute_model();
        run_inference(-1, 0, -1);
        for (int s = 0; s < T_STEPS; s++) begin
            n_checks++;
            if (obs_spk[s] !== '1) begin
                n_fail++;
                $display("FAIL sat_spikes step %0d: got %b required all ones", s, obs_spk[s]);
            end
        end
        n_checks++;
        if (obs_counts !== {N_OUT{CW'(SAT)}}) begin
            n_fail++;
            $display("FAIL sat_counts: got %h required %h", obs_counts, {N_OUT{CW'(SAT)}});
        end
        n_checks++;
        if (done_lat != 2 + T_STEPS * PERIOD) begin
            n_fail++;
            $display("FAIL done_latency: got %0d required %0d", done_lat, 2 + T_STEPS * PERIOD);
        end
        n_checks++;
        if (obs_lat[0] != PERIOD || obs_hs[1] - obs_hs[0] != PERIOD) begin
            n_fail++;
            $display("FAIL step_period: out_valid delay %0d period %0d required %0d %0d",
                     obs_lat[0], obs_hs[1] - obs_hs[0], PERIOD, PERIOD);
        end
        n_checks++;
        if (busy_ok !== 1'b1 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_window: during=%b after=%b required 1 0", busy_ok, busy_after);
        end
    endtask

    task automatic test_alignment;
        randomize_stim(20);
        for (int k = 0; k < N_OUT; k++) wmem[5][k] = 16'sd7;
        for (int s = 0; s < T_STEPS; s++) begin
            vs_spk[s] = N_IN'(1) << 5;
            vs_pol[s] = '0;
        end
        th = -7;
        compute_model();
        run_inference(-1, 0, -1);
        for (int s = 0; s < T_STEPS; s++) begin
            n_checks++;
            if (obs_pin[s] !== {1'b0, vs_spk[s], 1'b0} || obs_addr[s] !== exp_addr) begin
                n_fail++;
                $display("FAIL align step %0d: pe_in trace %b addr %h required %b %h",
                         s, obs_pin[s], obs_addr[s], {1'b0, vs_spk[s], 1'b0}, exp_addr);
            end
            n_checks++;
            if (obs_spk[s] !== exp_spk[s] || obs_ts[s] !== TW'(s)) begin
                n_fail++;
                $display("FAIL align_spikes step %0d: spikes %b ts %0d required %b %0d",
                         s, obs_spk[s], obs_ts[s], exp_spk[s], s);
            end
        end
        n_checks++;
        if (obs_counts !== exp_counts) begin
            n_fail++;
            $display("FAIL align_counts: got %h required %h", obs_counts, exp_counts);
        end
    endtask

    task automatic test_stall;
        randomize_stim(20);
        compute_model();
        run_inference(2, 10, -1);
        n_checks++;
        if (obs_hs[2] - obs_hs[1] != PERIOD + 10 || obs_hs[3] - obs_hs[2] != PERIOD) begin
            n_fail++;
            $display("FAIL stall_period: got %0d %0d required %0d %0d",
                     obs_hs[2] - obs_hs[1], obs_hs[3] - obs_hs[2], PERIOD + 10, PERIOD);
        end
        n_checks++;
        if (stall_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_idle: ready-high/no-issue flag %b required 1", stall_ok);
        end
        n_checks++;
        if (done_lat != 2 + T_STEPS * PERIOD + 10 || obs_counts !== exp_counts) begin
            n_fail++;
            $display("FAIL stall_result: latency %0d counts %h required %0d %h",
                     done_lat, obs_counts, 2 + T_STEPS * PERIOD + 10, exp_counts);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            randomize_stim(10 + 10 * it);
            compute_model();
            run_inference(-1, 0, -1);
            for (int s = 0; s < T_STEPS; s++) begin
                n_checks++;
                if (obs_spk[s] !== exp_spk[s] || obs_pin[s] !== {1'b0, vs_spk[s], 1'b0}) begin
                    n_fail++;
                    $display("FAIL rand%0d step %0d: spikes %b pe_in %b required %b %b",
                             it, s, obs_spk[s], obs_pin[s], exp_spk[s], {1'b0, vs_spk[s], 1'b0});
                end
            end
            n_checks++;
            if (obs_counts !== exp_counts) begin
                n_fail++;
                $display("FAIL rand%0d counts: got %h required %h", it, obs_counts, exp_counts);
            end
        end
    endtask

    task automatic test_restart;
        randomize_stim(20);
        compute_model();
        run_inference(-1, 0, -1);
        randomize_stim(20);
        compute_model();
        run_inference(-1, 0, 3);
        n_checks++;
        if (obs_counts !== exp_counts) begin
            n_fail++;
            $display("FAIL restart_counts: got %h required %h", obs_counts, exp_counts);
        end
        n_checks++;
        if (done_lat != 2 + T_STEPS * PERIOD) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d required %0d", done_lat, 2 + T_STEPS * PERIOD);
        end
        n_checks++;
        if (counts_after !== exp_counts || out_spikes !== exp_spk[T_STEPS-1]) begin
            n_fail++;
            $display("FAIL hold_after_done: counts %h spikes %b required %h %b",
                     counts_after, out_spikes, exp_counts, exp_spk[T_STEPS-1]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N_IN; i++) exp_addr[i*AW +: AW] = AW'(i);
        for (int r = 0; r < N_IN; r++)
            for (int k = 0; k < N_OUT; k++) wmem[r][k] = '0;
        th = 0;
        test_reset();
        test_saturation();
        test_alignment();
        test_stall();
        test_random();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snn_timestep_scheduler.md
Name: snn_timestep_scheduler

Overview:
- Sequences one inference through a 1-row array of N_OUT integrate-and-fire PEs. Each PE has clk, rstn, in_spike, in_polarity, a 16-bit signed in_weight and a threshold input, and produces a registered out_spike.
- For each of T_STEPS timesteps it:
  - accepts an input spike vector through a valid/ready handshake;
  - broadcasts one input row per cycle to all PEs, with a weight-memory read address;
  - waits out the PE latency;
  - samples and counts the output spikes.
- It clears PE membranes at inference start. It sits between the spike-input FIFO, the weight SRAM and the PE row.

Parameters:
N_IN, 16, input rows per timestep (spike vector length)
N_OUT, 8, PEs driven in parallel
T_STEPS, 8, timesteps per inference
LAT, 2, cycles from last PE integrate input to valid pe_out_spike
CW, 8, width of each output spike counter

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
start  in  1  begin inference; sampled in IDLE only
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when final counts are valid
spk_valid  in  1  spike vector valid
spk_ready  out  1  high only in WAIT_SPK
spk_data  in  2*N_IN  {polarity[N_IN-1:0], spike[N_IN-1:0]}
w_rd_addr  out  $clog2(N_IN)  weight SRAM row address; SRAM has 1-cycle read latency
pe_rstn  out  1  PE reset, active-low
pe_in_spike  out  1  broadcast spike to PEs
pe_in_polarity  out  1  broadcast polarity (1 = add, 0 = subtract)
pe_out_spike  in  N_OUT  PE output spikes
out_valid  out  1  one-cycle pulse per timestep
out_spikes  out  N_OUT  sampled spikes for the current timestep
spike_counts  out  N_OUT*CW  per-PE spike totals; PE k occupies bits [k*CW +: CW]
timestep  out  $clog2(T_STEPS)  index of the current timestep

Behaviour:
- Reset (rstn=0):
  - state IDLE; all outputs 0 except pe_rstn=0; counters and internal buffers cleared.
  - rstn low mid-inference aborts immediately. No done is generated.
- States: IDLE, CLEAR, WAIT_SPK, ISSUE, DRAIN, SAMPLE, FINISH.
- IDLE:
  - start=1 -> CLEAR. busy rises next cycle.
  - start while busy is ignored.
- CLEAR (1 cycle):
  - pe_rstn=0, pe_in_spike=0. pe_in_spike must be 0 in CLEAR because an integrate in the PE overrides its own reset.
  - spike_counts cleared; timestep=0. -> WAIT_SPK.
- WAIT_SPK:
  - spk_ready=1. On spk_valid&spk_ready, spk_data is latched into an internal buffer; row=0; -> ISSUE.
- ISSUE (exactly N_IN cycles, row 0..N_IN-1):
  - w_rd_addr=row combinationally in the same cycle.
  - At the closing edge, pe_in_spike<=spike[row] and pe_in_polarity<=polarity[row], so they align with SRAM data in the next cycle.
  - After row N_IN-1 -> DRAIN.
- pe_in_spike returns to 0 in the cycle after the last issued row's cycle and stays 0 outside that window.
- DRAIN (LAT cycles) -> SAMPLE.
- SAMPLE (1 cycle):
  - out_spikes<=pe_out_spike; out_valid pulses in the next cycle.
  - Each counter increments by its spike bit and saturates at 2^CW-1.
  - If timestep==T_STEPS-1 -> FINISH; else timestep++ and -> WAIT_SPK.
- FINISH (1 cycle): done=1; busy falls next cycle; -> IDLE.
  - Membranes persist until the next CLEAR.
  - spike_counts and out_spikes hold their values until the next CLEAR.
- Timestep period: N_IN+LAT+2 cycles when spk_valid is held high.
- spk_valid low in WAIT_SPK stalls indefinitely. There is no timeout and no PE activity during the stall.
- pe_rstn = rstn & ~(state==CLEAR).

Test Plan:
- Reset: rstn=0 for 3 cycles mid-ISSUE -> busy=0, pe_rstn=0, pe_in_spike=0, counts=0; afterwards IDLE with no done.
- Single timestep, T_STEPS=1, all spikes=1, polarity=1, weights=1, threshold=16 -> every PE out_spike=1 and every count=1; done exactly N_IN+LAT+4 cycles after start (1 CLEAR + 1 WAIT_SPK + N_IN ISSUE + LAT DRAIN + 1 SAMPLE + 1 FINISH).
- Alignment: spike only on row 5 with polarity=0 and weight[5]=7 -> membrane=-7. pe_in_spike is high only in the cycle after w_rd_addr=5.
- Stall: spk_valid low 10 cycles before timestep 2 -> spk_ready stays high and pe_in_spike stays 0; timestep period is extended by 10 cycles.
- Saturation: CW=2, T_STEPS=8, PE fires every timestep -> count=3, not wrapped.
- Restart: second start after done -> CLEAR zeroes counts and membranes; start asserted during busy has no effect.
